// File: rtl/usb3_host_in_xfer_if.sv
// Link-layer side of the host IN initiator: outgoing TP request and incoming TP/DPH/DPP status.
interface usb3_host_in_xfer_if;
    logic        tx_tp;
    logic        tx_tp_retry;
    logic        tx_tp_pktpend;
    logic        tx_tp_dir;
    logic [3:0]  tx_tp_subtype;
    logic [3:0]  tx_tp_endp;
    logic [4:0]  tx_tp_nump;
    logic [4:0]  tx_tp_seq;
    logic [15:0] tx_tp_stream;
    logic        tx_tp_ack;
    logic        rx_tp;
    logic [3:0]  rx_tp_subtype;
    logic [3:0]  rx_tp_endp;
    logic        rx_dph;
    logic [3:0]  rx_dph_endp;
    logic [4:0]  rx_dph_seq;
    logic [15:0] rx_dph_len;
    logic        rx_dpp_start;
    logic        rx_dpp_done;
    logic        rx_dpp_crcgood;

    modport master (
        output tx_tp, tx_tp_retry, tx_tp_pktpend, tx_tp_dir, tx_tp_subtype,
               tx_tp_endp, tx_tp_nump, tx_tp_seq, tx_tp_stream,
        input  tx_tp_ack,
        input  rx_tp, rx_tp_subtype, rx_tp_endp, rx_dph, rx_dph_endp, rx_dph_seq,
               rx_dph_len, rx_dpp_start, rx_dpp_done, rx_dpp_crcgood
    );

    modport slave (
        input  tx_tp, tx_tp_retry, tx_tp_pktpend, tx_tp_dir, tx_tp_subtype,
               tx_tp_endp, tx_tp_nump, tx_tp_seq, tx_tp_stream,
        output tx_tp_ack,
        output rx_tp, rx_tp_subtype, rx_tp_endp, rx_dph, rx_dph_endp, rx_dph_seq,
               rx_dph_len, rx_dpp_start, rx_dpp_done, rx_dpp_crcgood
    );
endinterface

// File: rtl/usb3_host_in_xfer.sv
// Host-side USB3 bulk/interrupt IN initiator: sends ACK TPs as IN requests, checks returned
// data packets, retries bad ones and follows the NRDY/ERDY flow control handshake.
module usb3_host_in_xfer #(
    parameter int MAX_NUMP  = 1,
    parameter int MAX_RETRY = 3,
    parameter int RESP_TMO  = 1000,
    parameter int START_TMO = 20,
    parameter int DONE_TMO  = 270
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic [4:0]  ltssm_state,
    input  logic        xfer_start,
    input  logic [3:0]  xfer_endp,
    input  logic [15:0] xfer_npkts,
    input  logic [4:0]  xfer_seq,
    output logic        xfer_busy,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic        pkt_good,
    output logic [15:0] pkt_len,
    output logic [4:0]  seq_next,
    output logic        err_miss_rx,
    usb3_host_in_xfer_if.master link
);

    // Link codes, values as in usb3_const.vh
    localparam logic [4:0] LT_U0              = 5'd16;
    localparam logic [3:0] LP_TP_SUB_ACK      = 4'd1;
    localparam logic [3:0] LP_TP_SUB_NRDY     = 4'd2;
    localparam logic [3:0] LP_TP_SUB_ERDY     = 4'd3;
    localparam logic       LP_TP_DEVICETOHOST = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT_RESP, S_WAIT_ERDY, S_WAIT_START,
        S_WAIT_DONE, S_CHECK, S_RETRY, S_DONE, S_ERR
    } state_t;

    state_t      state, state_next;
    logic [15:0] remaining;
    logic [15:0] timer;
    logic [4:0]  seq;
    logic [7:0]  retry_cnt;
    logic        tp_retry;
    logic [3:0]  endp;
    logic [4:0]  dph_seq;
    logic [15:0] dph_len;
    logic        crc_good;

    function automatic logic [4:0] sat_nump(input logic [15:0] rem);
        if (rem > 16'(MAX_NUMP)) return 5'(MAX_NUMP);
        return rem[4:0];
    endfunction

    logic in_req, tp_match, dph_match, pkt_ok, tp_miss, dph_miss;
    assign in_req    = (state == S_REQ);
    assign tp_match  = link.rx_tp && (link.rx_tp_endp == endp);
    assign dph_match = link.rx_dph && (link.rx_dph_endp == endp);
    assign pkt_ok    = crc_good && (dph_seq == seq);
    // A TP is only expected while waiting; in WAIT_RESP a coincident matching DPH takes priority.
    assign tp_miss   = link.rx_tp && !(state == S_WAIT_ERDY ||
                                       (state == S_WAIT_RESP && !dph_match));
    assign dph_miss  = link.rx_dph && (state != S_WAIT_RESP);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:       if (xfer_start) state_next = (xfer_npkts == 16'd0) ? S_DONE : S_REQ;
            S_REQ:        if (link.tx_tp_ack) state_next = (remaining == 16'd0) ? S_DONE : S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (dph_match)                                           state_next = S_WAIT_START;
                else if (tp_match && link.rx_tp_subtype == LP_TP_SUB_NRDY) state_next = S_WAIT_ERDY;
                else if (timer == 16'(RESP_TMO))                         state_next = S_RETRY;
            end
            S_WAIT_ERDY:  if (tp_match && link.rx_tp_subtype == LP_TP_SUB_ERDY) state_next = S_REQ;
            S_WAIT_START: begin
                if (link.rx_dpp_start)            state_next = S_WAIT_DONE;
                else if (timer == 16'(START_TMO)) state_next = S_RETRY;
            end
            S_WAIT_DONE: begin
                if (link.rx_dpp_done)            state_next = S_CHECK;
                else if (timer == 16'(DONE_TMO)) state_next = S_RETRY;
            end
            S_CHECK:      state_next = pkt_ok ? S_REQ : S_RETRY;
            S_RETRY:      state_next = (retry_cnt == 8'(MAX_RETRY)) ? S_ERR : S_REQ;
            S_DONE:       state_next = S_IDLE;
            S_ERR:        state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
        // Losing U0 aborts an active transfer; terminal states are left to finish their pulse.
        if (ltssm_state != LT_U0 && !(state inside {S_IDLE, S_DONE, S_ERR}))
            state_next = S_ERR;
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            remaining   <= '0;
            timer       <= '0;
            seq         <= '0;
            retry_cnt   <= '0;
            tp_retry    <= 1'b0;
            pkt_good    <= 1'b0;
            pkt_len     <= '0;
            err_miss_rx <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= (state_next != state) ? 16'd0 : timer + 16'd1;
            pkt_good <= 1'b0;
            unique case (state)
                S_IDLE: if (xfer_start && xfer_npkts != 16'd0) begin
                    remaining <= xfer_npkts;
                    seq       <= xfer_seq;
                    retry_cnt <= '0;
                    tp_retry  <= 1'b0;
                end
                S_WAIT_ERDY: if (state_next == S_REQ) tp_retry <= 1'b0;
                S_CHECK: if (state_next == S_REQ) begin
                    pkt_good  <= 1'b1;
                    pkt_len   <= dph_len;
                    seq       <= seq + 5'd1;
                    remaining <= remaining - 16'd1;
                    retry_cnt <= '0;
                    tp_retry  <= 1'b0;
                end
                S_RETRY: if (state_next == S_REQ) begin
                    retry_cnt <= retry_cnt + 8'd1;
                    tp_retry  <= 1'b1;
                end
                default: ;
            endcase
            if (tp_miss || dph_miss) err_miss_rx <= 1'b1;
        end
    end

    always_ff @(posedge local_clk) begin
        if (state == S_IDLE && xfer_start) endp <= xfer_endp;
        if (state == S_WAIT_RESP && dph_match) begin
            dph_seq <= link.rx_dph_seq;
            dph_len <= link.rx_dph_len;
        end
        if (state == S_WAIT_DONE && link.rx_dpp_done) crc_good <= link.rx_dpp_crcgood;
    end

    assign xfer_busy = (state != S_IDLE);
    assign xfer_done = (state == S_DONE);
    assign xfer_err  = (state == S_ERR);
    assign seq_next  = seq;

    // TP fields are only driven while requesting so the link sees all-zero outside REQ.
    assign link.tx_tp         = in_req;
    assign link.tx_tp_retry   = in_req && tp_retry;
    assign link.tx_tp_pktpend = in_req && (remaining != 16'd0);
    assign link.tx_tp_dir     = in_req && LP_TP_DEVICETOHOST;
    assign link.tx_tp_subtype = in_req ? LP_TP_SUB_ACK : 4'd0;
    assign link.tx_tp_endp    = in_req ? endp : 4'd0;
    assign link.tx_tp_nump    = in_req ? sat_nump(remaining) : 5'd0;
    assign link.tx_tp_seq     = in_req ? seq : 5'd0;
    assign link.tx_tp_stream  = 16'd0;

endmodule

// File: tb/tb_usb3_host_in_xfer.sv
// Bench for usb3_host_in_xfer: acts as link layer and device, predicting each TP and outcome.
module tb_usb3_host_in_xfer;
    localparam logic [4:0] LT_U0     = 5'd16;
    localparam logic [4:0] LT_OTHER  = 5'd5;
    localparam logic [3:0] SUB_ACK   = 4'd1;
    localparam logic [3:0] SUB_NRDY  = 4'd2;
    localparam logic [3:0] SUB_ERDY  = 4'd3;
    localparam int         MAX_NUMP  = 1;
    localparam int         MAX_RETRY = 3;

    logic        local_clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ltssm_state;
    logic        xfer_start;
    logic [3:0]  xfer_endp;
    logic [15:0] xfer_npkts;
    logic [4:0]  xfer_seq;
    logic        xfer_busy, xfer_done, xfer_err, pkt_good, err_miss_rx;
    logic [15:0] pkt_len;
    logic [4:0]  seq_next;

    usb3_host_in_xfer_if link();

    usb3_host_in_xfer #(.MAX_NUMP(MAX_NUMP), .MAX_RETRY(MAX_RETRY)) dut (
        .local_clk(local_clk), .reset_n(reset_n), .ltssm_state(ltssm_state),
        .xfer_start(xfer_start), .xfer_endp(xfer_endp), .xfer_npkts(xfer_npkts),
        .xfer_seq(xfer_seq), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .xfer_err(xfer_err), .pkt_good(pkt_good), .pkt_len(pkt_len),
        .seq_next(seq_next), .err_miss_rx(err_miss_rx), .link(link)
    );

    always #5 local_clk = ~local_clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, good_cnt = 0;
    int plan[$];
    int erdy_delay = 50;

    always @(negedge local_clk) begin
        if (xfer_done) done_cnt <= done_cnt + 1;
        if (xfer_err)  err_cnt  <= err_cnt + 1;
        if (pkt_good)  good_cnt <= good_cnt + 1;
    end

    function automatic logic [36:0] exp_tp(input bit r, input int rem, input logic [4:0] s,
                                           input logic [3:0] e);
        int nump;
        nump = (rem < MAX_NUMP) ? rem : MAX_NUMP;
        return {r, rem != 0, 1'b1, SUB_ACK, e, 5'(nump), s, 16'h0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge local_clk);
    endtask

    task automatic start_xfer(input logic [3:0] e, input logic [15:0] n, input logic [4:0] s);
        xfer_start = 1'b1; xfer_endp = e; xfer_npkts = n; xfer_seq = s;
        @(negedge local_clk);
        xfer_start = 1'b0;
    endtask

    task automatic get_tp(input int bound, output bit ok, output logic [36:0] f, output int waited);
        ok = 1'b0; waited = 0; f = '0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge local_clk);
            if (link.tx_tp) begin ok = 1'b1; waited = i; break; end
        end
        if (ok) begin
            f = {link.tx_tp_retry, link.tx_tp_pktpend, link.tx_tp_dir, link.tx_tp_subtype,
                 link.tx_tp_endp, link.tx_tp_nump, link.tx_tp_seq, link.tx_tp_stream};
            link.tx_tp_ack = 1'b1;
            @(negedge local_clk);
            link.tx_tp_ack = 1'b0;
        end
    endtask

    task automatic send_data(input logic [3:0] e, input logic [4:0] s, input logic [15:0] len,
                             input logic crc);
        link.rx_dph = 1'b1; link.rx_dph_endp = e; link.rx_dph_seq = s; link.rx_dph_len = len;
        @(negedge local_clk);
        link.rx_dph = 1'b0; link.rx_dpp_start = 1'b1;
        @(negedge local_clk);
        link.rx_dpp_start = 1'b0; link.rx_dpp_done = 1'b1; link.rx_dpp_crcgood = crc;
        @(negedge local_clk);
        link.rx_dpp_done = 1'b0; link.rx_dpp_crcgood = 1'b0;
    endtask

    // Device model: plan holds per-request replies (0 good, 1 bad crc, 2 wrong seq, 3 NRDY/ERDY).
    task automatic run_xfer(input logic [3:0] e, input int n, input logic [4:0] s);
        int d0, e0, g0, rem, consec, goods, act, ai, w;
        bit rf, exp_err, ok, saw;
        logic [4:0] es;
        logic [15:0] elen, len;
        logic [36:0] f;
        d0 = done_cnt; e0 = err_cnt; g0 = good_cnt;
        es = s; rem = n; consec = 0; goods = 0; ai = 0; rf = 0; exp_err = 0; elen = '0;
        start_xfer(e, 16'(n), s);
        for (int it = 0; it < 64; it++) begin
            get_tp(40, ok, f, w);
            checks++;
            if (!ok) begin errors++; $display("FAIL tp_wait: no TP within 40 cycles, want one"); break; end
            checks++;
            if (f !== exp_tp(rf, rem, es, e)) begin
                errors++; $display("FAIL tp_fields: got %h want %h", f, exp_tp(rf, rem, es, e));
            end
            if (rem == 0) break;
            act = (ai < plan.size()) ? plan[ai] : 0;
            ai++;
            if (act == 0) begin
                len = 16'($urandom);
                send_data(e, es, len, 1'b1);
                es = es + 5'd1; rem--; rf = 0; consec = 0; goods++; elen = len;
            end else if (act == 1 || act == 2) begin
                send_data(e, (act == 1) ? es : es + 5'd1, 16'($urandom), act == 2);
                if (consec == MAX_RETRY) begin exp_err = 1; break; end
                consec++; rf = 1;
            end else begin
                link.rx_tp = 1'b1; link.rx_tp_subtype = SUB_NRDY; link.rx_tp_endp = e;
                @(negedge local_clk);
                link.rx_tp_subtype = SUB_ERDY; link.rx_tp_endp = e + 4'd1;
                @(negedge local_clk);
                link.rx_tp = 1'b0; saw = 0;
                repeat (erdy_delay) begin @(negedge local_clk); if (link.tx_tp) saw = 1; end
                checks++;
                if (saw) begin errors++; $display("FAIL nrdy_hold: TP seen=1 before ERDY, want 0"); end
                link.rx_tp = 1'b1; link.rx_tp_subtype = SUB_ERDY; link.rx_tp_endp = e;
                @(negedge local_clk);
                link.rx_tp = 1'b0;
                rf = 0;
            end
        end
        tick(4);
        checks++;
        if (done_cnt - d0 !== (exp_err ? 0 : 1)) begin
            errors++; $display("FAIL done_pulses: got %0d want %0d", done_cnt - d0, exp_err ? 0 : 1);
        end
        checks++;
        if (err_cnt - e0 !== (exp_err ? 1 : 0)) begin
            errors++; $display("FAIL err_pulses: got %0d want %0d", err_cnt - e0, exp_err ? 1 : 0);
        end
        checks++;
        if (good_cnt - g0 !== goods) begin
            errors++; $display("FAIL good_pulses: got %0d want %0d", good_cnt - g0, goods);
        end
        checks++;
        if (xfer_busy !== 1'b0 || seq_next !== es) begin
            errors++; $display("FAIL end_state: busy %b seq_next %0d want busy 0 seq_next %0d",
                               xfer_busy, seq_next, es);
        end
        if (goods > 0) begin
            checks++;
            if (pkt_len !== elen) begin errors++; $display("FAIL pkt_len: got %h want %h", pkt_len, elen); end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        checks++;
        if ({xfer_busy, xfer_done, xfer_err, pkt_good, pkt_len, seq_next, err_miss_rx} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0",
                               {xfer_busy, xfer_done, xfer_err, pkt_good, pkt_len, seq_next, err_miss_rx});
        end
        checks++;
        if ({link.tx_tp, link.tx_tp_retry, link.tx_tp_pktpend, link.tx_tp_dir, link.tx_tp_subtype,
             link.tx_tp_endp, link.tx_tp_nump, link.tx_tp_seq, link.tx_tp_stream} !== '0) begin
            errors++; $display("FAIL reset_tp: got tx_tp %b dir %b subtype %0d want all 0",
                               link.tx_tp, link.tx_tp_dir, link.tx_tp_subtype);
        end
    endtask

    task automatic test_basic;
        plan = '{0, 0};
        run_xfer(4'd3, 2, 5'd5);
    endtask

    task automatic test_nrdy;
        erdy_delay = 50;
        plan = '{3, 0};
        run_xfer(4'd7, 1, 5'd9);
    endtask

    task automatic test_bad_crc;
        plan = '{1, 0, 1, 1, 1, 1};
        run_xfer(4'd2, 3, 5'd0);
    endtask

    task automatic test_seq_wrap;
        plan = '{0, 0};
        run_xfer(4'd1, 2, 5'd31);
    endtask

    task automatic test_zero_npkts;
        start_xfer(4'd4, 16'd0, 5'd7);
        checks++;
        if (xfer_done !== 1'b1 || xfer_busy !== 1'b1 || link.tx_tp !== 1'b0) begin
            errors++; $display("FAIL zero_done: done %b busy %b tp %b want 1 1 0",
                               xfer_done, xfer_busy, link.tx_tp);
        end
        tick(1);
        checks++;
        if (xfer_done !== 1'b0 || xfer_busy !== 1'b0) begin
            errors++; $display("FAIL zero_idle: done %b busy %b want 0 0", xfer_done, xfer_busy);
        end
    endtask

    task automatic test_timeout_abort;
        bit ok;
        logic [36:0] f;
        int w;
        start_xfer(4'd6, 16'd1, 5'd12);
        get_tp(40, ok, f, w);
        checks++;
        if (!ok || f !== exp_tp(0, 1, 5'd12, 4'd6)) begin
            errors++; $display("FAIL tmo_first_tp: ok %b got %h want %h", ok, f, exp_tp(0, 1, 5'd12, 4'd6));
        end
        get_tp(1100, ok, f, w);
        checks++;
        if (!ok || w < 1000 || w > 1002) begin
            errors++; $display("FAIL tmo_delay: ok %b waited %0d want 1000..1002", ok, w);
        end
        checks++;
        if (f !== exp_tp(1, 1, 5'd12, 4'd6)) begin
            errors++; $display("FAIL tmo_retry_tp: got %h want %h", f, exp_tp(1, 1, 5'd12, 4'd6));
        end
        link.rx_dph = 1'b1; link.rx_dph_endp = 4'd6; link.rx_dph_seq = 5'd12; link.rx_dph_len = 16'd64;
        @(negedge local_clk);
        link.rx_dph = 1'b0; link.rx_dpp_start = 1'b1;
        @(negedge local_clk);
        link.rx_dpp_start = 1'b0;
        ltssm_state = LT_OTHER;
        @(negedge local_clk);
        checks++;
        if (xfer_err !== 1'b1) begin errors++; $display("FAIL ltssm_abort: err %b want 1", xfer_err); end
        ltssm_state = LT_U0;
        @(negedge local_clk);
        checks++;
        if (xfer_busy !== 1'b0 || xfer_err !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy %b err %b want 0 0", xfer_busy, xfer_err);
        end
    endtask

    task automatic test_reset_mid;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_xfer(4'd2, 16'd3, 5'd0);
        checks++;
        if (link.tx_tp !== 1'b1) begin errors++; $display("FAIL mid_req: tp %b want 1", link.tx_tp); end
        reset_n = 1'b0;
        @(negedge local_clk);
        checks++;
        if (link.tx_tp !== 1'b0 || xfer_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: tp %b busy %b want 0 0", link.tx_tp, xfer_busy);
        end
        reset_n = 1'b1;
        tick(4);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++; $display("FAIL mid_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_miss_rx;
        bit ok;
        logic [36:0] f;
        int w;
        checks++;
        if (err_miss_rx !== 1'b0) begin errors++; $display("FAIL miss_clear: got %b want 0", err_miss_rx); end
        start_xfer(4'd9, 16'd1, 5'd3);
        get_tp(40, ok, f, w);
        link.rx_dph = 1'b1; link.rx_dph_endp = 4'd9; link.rx_dph_seq = 5'd3; link.rx_dph_len = 16'd8;
        @(negedge local_clk);
        link.rx_dph = 1'b0;
        link.rx_tp = 1'b1; link.rx_tp_subtype = SUB_ERDY; link.rx_tp_endp = 4'd9;
        @(negedge local_clk);
        link.rx_tp = 1'b0;
        checks++;
        if (err_miss_rx !== 1'b1) begin errors++; $display("FAIL miss_set: got %b want 1", err_miss_rx); end
        link.rx_dpp_start = 1'b1;
        @(negedge local_clk);
        link.rx_dpp_start = 1'b0; link.rx_dpp_done = 1'b1; link.rx_dpp_crcgood = 1'b1;
        @(negedge local_clk);
        link.rx_dpp_done = 1'b0;
        get_tp(40, ok, f, w);
        checks++;
        if (!ok || f !== exp_tp(0, 0, 5'd4, 4'd9)) begin
            errors++; $display("FAIL miss_final_tp: ok %b got %h want %h", ok, f, exp_tp(0, 0, 5'd4, 4'd9));
        end
        tick(3);
        checks++;
        if (err_miss_rx !== 1'b1) begin errors++; $display("FAIL miss_sticky: got %b want 1", err_miss_rx); end
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        checks++;
        if (err_miss_rx !== 1'b0) begin errors++; $display("FAIL miss_reset: got %b want 0", err_miss_rx); end
    endtask

    task automatic test_random;
        int r;
        for (int t = 0; t < 8; t++) begin
            plan.delete();
            for (int k = 0; k < 12; k++) begin
                r = $urandom_range(0, 99);
                plan.push_back(r < 60 ? 0 : r < 75 ? 1 : r < 85 ? 2 : 3);
            end
            erdy_delay = $urandom_range(1, 60);
            run_xfer(4'($urandom_range(0, 15)), $urandom_range(1, 4), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        reset_n = 1'b0; ltssm_state = LT_U0;
        xfer_start = 1'b0; xfer_endp = '0; xfer_npkts = '0; xfer_seq = '0;
        link.tx_tp_ack = 1'b0; link.rx_tp = 1'b0; link.rx_tp_subtype = '0; link.rx_tp_endp = '0;
        link.rx_dph = 1'b0; link.rx_dph_endp = '0; link.rx_dph_seq = '0; link.rx_dph_len = '0;
        link.rx_dpp_start = 1'b0; link.rx_dpp_done = 1'b0; link.rx_dpp_crcgood = 1'b0;
        @(negedge local_clk);
        test_reset();
        test_basic();
        test_nrdy();
        test_bad_crc();
        test_seq_wrap();
        test_zero_npkts();
        test_timeout_abort();
        test_reset_mid();
        test_miss_rx();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
